// File: rtl/router_pkg.sv
// Shared router types: flit layout plus the injection arbiter state enum and flit helpers.
package router_pkg;

   localparam int FLIT_SIZE = 16;

   typedef enum logic [1:0] {
      HEAD_FLIT     = 2'd0,
      BODY_FLIT     = 2'd1,
      TAIL_FLIT     = 2'd2,
      HEADTAIL_FLIT = 2'd3
   } FLIT_TYPE_t;

   typedef struct packed {
      FLIT_TYPE_t flit_type;
      logic [4:0] dest;
   } HEAD_t;

   // valid sits in the MSB so flit[FLIT_SIZE-1] is the valid bit
   typedef struct packed {
      logic       valid;
      HEAD_t      head;
      logic [7:0] payload;
   } FLIT_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } ARB_STATE_t;

   function automatic logic flit_valid(input FLIT_t f);
      logic [FLIT_SIZE-1:0] bits;
      bits = f;
      return bits[FLIT_SIZE-1];
   endfunction

   function automatic logic is_tail(input FLIT_t f);
      return flit_valid(f) && (f.head.flit_type == TAIL_FLIT);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_SRC.
module rr_picker #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] ptr,
   output logic [$clog2(NUM_SRC)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_SRC);

   // scan from the farthest offset down so the nearest request to ptr is written last
   always_comb begin
      int j;
      j   = 0;
      idx = '0;
      any = |req;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         if (req[IDX_W'(j)]) idx = IDX_W'(j);
      end
   end

endmodule

// File: rtl/injection_arbiter.sv
// Packet-granular round-robin arbiter sharing one router injection port among NUM_SRC sources.
module injection_arbiter
   import router_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int MAX_IDLE = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_SRC-1:0]         i_src_req,
   input  FLIT_t [NUM_SRC-1:0]        i_src_flit,
   output logic [NUM_SRC-1:0]         o_src_send,
   output logic                       o_rtr_req,
   input  logic                       i_rtr_ack,
   output FLIT_t                      o_flit,
   output logic                       o_busy,
   output logic                       o_abort,
   output logic [$clog2(NUM_SRC)-1:0] o_grant_idx
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(MAX_IDLE + 1);

   ARB_STATE_t       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   FLIT_t            flit_q, flit_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   FLIT_t            cur_flit;
   logic             cur_valid, cur_tail, wd_hit;

   rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
      .req (i_src_req),
      .ptr (rr_ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign cur_flit  = i_src_flit[grant_idx_q];
   assign cur_valid = flit_valid(cur_flit);
   assign cur_tail  = is_tail(cur_flit);
   // a valid flit (including a tail) on the terminal count always beats the watchdog
   assign wd_hit    = (idle_cnt_q == CNT_W'(MAX_IDLE - 1)) && !cur_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         idle_cnt_q  <= '0;
         flit_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         idle_cnt_q  <= idle_cnt_d;
         flit_q      <= flit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (pick_any) state_d = REQ;
         REQ: begin
            if (!i_src_req[grant_idx_q]) state_d = IDLE;
            else if (i_rtr_ack)          state_d = XFER;
         end
         XFER: if (cur_tail || wd_hit) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      idle_cnt_d  = idle_cnt_q;
      flit_d      = '0;
      case (state_q)
         IDLE: begin
            idle_cnt_d = '0;
            if (pick_any) grant_idx_d = pick_idx;
         end
         XFER: begin
            if (cur_valid) begin
               flit_d     = cur_flit;
               idle_cnt_d = '0;
            end else if (idle_cnt_q != CNT_W'(MAX_IDLE)) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         DONE: begin
            idle_cnt_d = '0;
            rr_ptr_d   = (grant_idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_src_send  = '0;
      o_rtr_req   = (state_q == REQ) || (state_q == XFER);
      o_busy      = (state_q != IDLE);
      o_abort     = (state_q == XFER) && wd_hit;
      o_flit      = flit_q;
      o_grant_idx = grant_idx_q;
      if ((state_q == XFER) ||
          ((state_q == REQ) && i_rtr_ack && i_src_req[grant_idx_q]))
         o_src_send[grant_idx_q] = 1'b1;
   end

endmodule

// File: tb/tb_injection_arbiter.sv
// Directed bench for injection_arbiter: single packet, round-robin order, wrap/skip, watchdog, collision, mid-packet reset.
module tb_injection_arbiter;
   import router_pkg::*;

   localparam int NUM_SRC  = 4;
   localparam int MAX_IDLE = 8;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NUM_SRC-1:0]   i_src_req = '0;
   FLIT_t [NUM_SRC-1:0]  i_src_flit = '0;
   logic [NUM_SRC-1:0]   o_src_send;
   logic                 o_rtr_req;
   logic                 i_rtr_ack = 1'b0;
   FLIT_t                o_flit;
   logic                 o_busy;
   logic                 o_abort;
   logic [1:0]           o_grant_idx;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   injection_arbiter #(.NUM_SRC(NUM_SRC), .MAX_IDLE(MAX_IDLE)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_src_req   (i_src_req),
      .i_src_flit  (i_src_flit),
      .o_src_send  (o_src_send),
      .o_rtr_req   (o_rtr_req),
      .i_rtr_ack   (i_rtr_ack),
      .o_flit      (o_flit),
      .o_busy      (o_busy),
      .o_abort     (o_abort),
      .o_grant_idx (o_grant_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [7:0] d);
      FLIT_t f;
      f.valid          = 1'b1;
      f.head.flit_type = t;
      f.head.dest      = 5'd1;
      f.payload        = d;
      return f;
   endfunction

   // non-granted sources always drive valid tail flits that must be ignored
   task automatic set_flit(input int src, input FLIT_t f);
      for (int s = 0; s < NUM_SRC; s++)
         i_src_flit[s] = (s == src) ? f : mk(TAIL_FLIT, 8'hEE);
   endtask

   // IDLE cycle, ack_dly REQ cycles without ack, then the ack cycle
   task automatic arb_grant(input logic [3:0] mask, input int exp, input int ack_dly);
      @(negedge clk);
      i_src_req = mask;
      i_rtr_ack = 1'b0;
      set_flit(exp, FLIT_t'('0));
      #1;
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_rtr_req", 32'(o_rtr_req), 32'd0);
      check("idle_flit", 32'(o_flit), 32'd0);
      for (int k = 0; k < ack_dly; k++) begin
         @(negedge clk);
         #1;
         check("req_rtr_req", 32'(o_rtr_req), 32'd1);
         check("req_send", 32'(o_src_send), 32'd0);
         check("req_gidx", 32'(o_grant_idx), 32'(exp));
      end
      @(negedge clk);
      i_rtr_ack = 1'b1;
      #1;
      check("ack_send", 32'(o_src_send), 32'(1 << exp));
      check("ack_gidx", 32'(o_grant_idx), 32'(exp));
   endtask

   // head, nbody bodies, tail; then the DONE bubble
   task automatic arb_stream(input int src, input int nbody);
      FLIT_t exp_q, f;
      exp_q = '0;
      for (int k = 0; k < nbody + 2; k++) begin
         @(negedge clk);
         i_rtr_ack = 1'b0;
         if (k == 0)              f = mk(HEAD_FLIT, 8'(src * 16 + k));
         else if (k == nbody + 1) f = mk(TAIL_FLIT, 8'(src * 16 + k));
         else                     f = mk(BODY_FLIT, 8'(src * 16 + k));
         set_flit(src, f);
         #1;
         check("xfer_send", 32'(o_src_send), 32'(1 << src));
         check("xfer_flit", 32'(o_flit), 32'(exp_q));
         check("xfer_abort", 32'(o_abort), 32'd0);
         exp_q = f;
      end
      @(negedge clk);
      set_flit(src, FLIT_t'('0));
      #1;
      check("done_flit", 32'(o_flit), 32'(exp_q));
      check("done_send", 32'(o_src_send), 32'd0);
      check("done_rtr_req", 32'(o_rtr_req), 32'd0);
      check("done_busy", 32'(o_busy), 32'd1);
   endtask

   // head then stall; collide=1 delivers the tail on the terminal idle count
   task automatic arb_watchdog(input int src, input bit collide);
      FLIT_t h, t;
      h = mk(HEAD_FLIT, 8'hA0);
      t = mk(TAIL_FLIT, 8'hAF);
      @(negedge clk);
      i_rtr_ack = 1'b0;
      set_flit(src, h);
      #1;
      check("wd_head_flit", 32'(o_flit), 32'd0);
      for (int k = 1; k <= MAX_IDLE; k++) begin
         @(negedge clk);
         set_flit(src, (collide && k == MAX_IDLE) ? t : FLIT_t'('0));
         #1;
         check("wd_send", 32'(o_src_send), 32'(1 << src));
         check("wd_flit", 32'(o_flit), (k == 1) ? 32'(h) : 32'd0);
         check("wd_abort", 32'(o_abort), (k == MAX_IDLE && !collide) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      set_flit(src, FLIT_t'('0));
      #1;
      check("wd_done_send", 32'(o_src_send), 32'd0);
      check("wd_done_abort", 32'(o_abort), 32'd0);
      check("wd_done_busy", 32'(o_busy), 32'd1);
      check("wd_done_flit", 32'(o_flit), collide ? 32'(t) : 32'd0);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_send", 32'(o_src_send), 32'd0);
      check("rst_rtr_req", 32'(o_rtr_req), 32'd0);
      check("rst_flit", 32'(o_flit), 32'd0);
      check("rst_abort", 32'(o_abort), 32'd0);
      check("rst_gidx", 32'(o_grant_idx), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // single source 2, ack after 3 REQ cycles, H,B,B,T
      arb_grant(4'b0100, 2, 3);
      arb_stream(2, 2);

      // rr_ptr is now 3: all requesting picks 3, then 0,1,2,3,0
      arb_grant(4'b1111, 3, 0);
      arb_stream(3, 1);
      for (int n = 0; n < 5; n++) begin
         arb_grant(4'b1111, n % 4, 0);
         arb_stream(n % 4, 1);
      end

      // rr_ptr=1; a src2 packet moves it to 3, then src1 alone wraps past 3,0
      arb_grant(4'b0100, 2, 0);
      arb_stream(2, 0);
      arb_grant(4'b0010, 1, 1);
      arb_stream(1, 1);

      // rr_ptr=2: watchdog abort on src2
      arb_grant(4'b1111, 2, 0);
      arb_watchdog(2, 1'b0);

      // rr_ptr=3: reset during the body flit of src3
      arb_grant(4'b1111, 3, 0);
      @(negedge clk);
      i_rtr_ack = 1'b0;
      set_flit(3, mk(HEAD_FLIT, 8'h30));
      @(negedge clk);
      set_flit(3, mk(BODY_FLIT, 8'h31));
      #1;
      check("mid_flit_pre", 32'(o_flit), 32'(mk(HEAD_FLIT, 8'h30)));
      reset_n   = 1'b0;
      i_src_req = '0;
      #1;
      check("mid_rst_flit", 32'(o_flit), 32'd0);
      check("mid_rst_send", 32'(o_src_send), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_rtr_req", 32'(o_rtr_req), 32'd0);
      @(negedge clk);
      set_flit(0, FLIT_t'('0));
      reset_n = 1'b1;

      // src1 drops its request before ack: back to IDLE, rr_ptr untouched
      @(negedge clk);
      i_src_req = 4'b0010;
      @(negedge clk);
      i_src_req = 4'b0000;
      #1;
      check("drop_rtr_req", 32'(o_rtr_req), 32'd1);
      check("drop_send", 32'(o_src_send), 32'd0);
      @(negedge clk);
      #1;
      check("drop_idle_busy", 32'(o_busy), 32'd0);

      // rr_ptr=0 after reset: tail collides with terminal idle count
      arb_grant(4'b1111, 0, 0);
      arb_watchdog(0, 1'b1);
      arb_grant(4'b1111, 1, 0);
      arb_stream(1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
